punc_state_dumper: RTL and testbench

- Sits directly downstream of the PUnC processor top level and consumes its debug outputs (pc_debug_data, rf_debug_data, mem_debug_data) by driving its debug address inputs.
- On a software start pulse, or automatically when the processor is detected as halted, it emits an architectural-state snapshot as a valid/ready word stream: PC, then R0..R7, then a memory window.
- The stream feeds the trace/UART sink.

---
 rtl/punc_state_dumper.sv | 232 +++++++++++++++++++++++
 tb/tb_punc_state_dumper.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_state_dumper.sv
`default_nettype none
// ============================================================================
// Module      : punc_state_dumper
// Description : Walks the PUnC debug ports and streams an architectural-state
//               snapshot (PC, R0..R7, memory window) as valid/ready words.
//               A dump starts on a start pulse, or on the rising edge of the
//               internal halt detector when auto_en is set.
// Revision    : 1.0 - initial release
// ============================================================================
module punc_state_dumper #(
  parameter logic [15:0] MEM_BASE    = 16'h3000,
  parameter int unsigned MEM_WORDS   = 16,
  parameter int unsigned HALT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  input  logic [15:0] pc_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] mem_debug_data,
  output logic [2:0]  rf_debug_addr,
  output logic [15:0] mem_debug_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_tag,
  output logic [15:0] out_idx,
  output logic        busy,
  output logic        done,
  output logic        halted
);

  // Section tags carried on out_tag
  localparam logic [1:0]  c_TAG_PC    = 2'b00;
  localparam logic [1:0]  c_TAG_RF    = 2'b01;
  localparam logic [1:0]  c_TAG_MEM   = 2'b10;

  // Last register index and last memory index within their sections.
  // c_MEM_LAST is only consulted when the memory window is non-empty.
  localparam logic [15:0] c_RF_LAST   = 16'd7;
  localparam logic [15:0] c_MEM_LAST  = 16'(MEM_WORDS - 1);
  localparam logic        c_MEM_EMPTY = (MEM_WORDS == 0);

  // Halt counter saturates at its 8-bit maximum
  localparam logic [7:0]  c_CNT_MAX   = 8'hFF;
  localparam logic [7:0]  c_HALT_THR  = 8'(HALT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PC_RD  = 3'd1,
    S_OUT    = 3'd2,
    S_RF_RD  = 3'd3,
    S_MEM_RD = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t      state_q,    state_d;
  logic [2:0]  rf_addr_q,  rf_addr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] idx_q,      idx_d;
  logic        valid_q,    valid_d;
  logic [15:0] data_q,     data_d;
  logic [1:0]  tag_q,      tag_d;
  logic [15:0] oidx_q,     oidx_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;

  logic [15:0] prev_pc_q;
  logic [7:0]  hcnt_q,     hcnt_d;
  logic        halted_q,   halted_d;
  logic        halted_dly_q;

  logic        w_halt_rise;
  logic        w_trigger;

  // Halt detector: count consecutive cycles with an unchanged PC
  always_comb begin
    hcnt_d = 8'd0;
    if (pc_debug_data == prev_pc_q) begin
      hcnt_d = (hcnt_q == c_CNT_MAX) ? c_CNT_MAX : hcnt_q + 8'd1;
    end
    halted_d = (hcnt_d >= c_HALT_THR);
  end

  // A halt only triggers on its 0->1 edge; a steady halt never re-triggers,
  // and an edge seen while busy is simply lost rather than queued.
  assign w_halt_rise = halted_q & ~halted_dly_q;
  assign w_trigger   = start | (auto_en & w_halt_rise);

  // Next-state and datapath: every register holds unless a state updates it
  always_comb begin
    state_d    = state_q;
    rf_addr_d  = rf_addr_q;
    mem_addr_d = mem_addr_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    data_d     = data_q;
    tag_d      = tag_q;
    oidx_d     = oidx_q;
    busy_d     = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (w_trigger) begin
          state_d    = S_PC_RD;
          busy_d     = 1'b1;
          rf_addr_d  = 3'd0;
          mem_addr_d = MEM_BASE;
          idx_d      = 16'd0;
        end
      end

      // Read states sample debug data one full cycle after the address moved
      S_PC_RD: begin
        data_d  = pc_debug_data;
        tag_d   = c_TAG_PC;
        oidx_d  = 16'd0;
        valid_d = 1'b1;
        state_d = S_OUT;
      end

      S_RF_RD: begin
        data_d  = rf_debug_data;
        tag_d   = c_TAG_RF;
        oidx_d  = idx_q;
        valid_d = 1'b1;
        state_d = S_OUT;
      end

      S_MEM_RD: begin
        data_d  = mem_debug_data;
        tag_d   = c_TAG_MEM;
        oidx_d  = idx_q;
        valid_d = 1'b1;
        state_d = S_OUT;
      end

      // Word held until accepted; the tag of the word just sent picks the
      // next section step.
      S_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (tag_q == c_TAG_PC) begin
            idx_d   = 16'd0;
            state_d = S_RF_RD;
          end else if (tag_q == c_TAG_RF) begin
            if (idx_q != c_RF_LAST) begin
              idx_d     = idx_q + 16'd1;
              rf_addr_d = rf_addr_q + 3'd1;
              state_d   = S_RF_RD;
            end else if (c_MEM_EMPTY) begin
              state_d = S_FIN;
            end else begin
              idx_d   = 16'd0;
              state_d = S_MEM_RD;
            end
          end else begin
            if (idx_q != c_MEM_LAST) begin
              idx_d      = idx_q + 16'd1;
              mem_addr_d = mem_addr_q + 16'd1;
              state_d    = S_MEM_RD;
            end else begin
              state_d = S_FIN;
            end
          end
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    // done is high exactly for the single FIN cycle
    done_d = (state_d == S_FIN);
  end

  // State and output registers; reset aborts any dump in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rf_addr_q    <= 3'd0;
      mem_addr_q   <= MEM_BASE;
      idx_q        <= 16'd0;
      valid_q      <= 1'b0;
      data_q       <= 16'd0;
      tag_q        <= 2'b00;
      oidx_q       <= 16'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      prev_pc_q    <= 16'd0;
      hcnt_q       <= 8'd0;
      halted_q     <= 1'b0;
      halted_dly_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      mem_addr_q   <= mem_addr_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      oidx_q       <= oidx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      prev_pc_q    <= pc_debug_data;
      hcnt_q       <= hcnt_d;
      halted_q     <= halted_d;
      halted_dly_q <= halted_q;
    end
  end

  assign rf_debug_addr  = rf_addr_q;
  assign mem_debug_addr = mem_addr_q;
  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_tag        = tag_q;
  assign out_idx        = oidx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign halted         = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_punc_state_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_punc_state_dumper
// Description : Self-checking bench for punc_state_dumper. Three instances
//               cover the 3000/4 window, the FFFE/3 wrapping window and the
//               empty window. Expected streams come from a word-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_punc_state_dumper;

  localparam int N_DUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        start_s  [N_DUT];
  logic        auto_s   [N_DUT];
  logic        ready_s  [N_DUT];
  logic [15:0] rf_data_s[N_DUT];
  logic [15:0] mem_data_s[N_DUT];

  logic [2:0]  rf_addr_w [N_DUT];
  logic [15:0] mem_addr_w[N_DUT];
  logic        valid_w   [N_DUT];
  logic [15:0] data_w    [N_DUT];
  logic [1:0]  tag_w     [N_DUT];
  logic [15:0] idx_w     [N_DUT];
  logic        busy_w    [N_DUT];
  logic        done_w    [N_DUT];
  logic        halted_w  [N_DUT];

  logic [15:0] rf_model[8];
  logic        mem_fixed;
  logic [15:0] salt;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] base_of(input int d);
    if (d == 1) return 16'hFFFE;
    return 16'h3000;
  endfunction

  function automatic int words_of(input int d);
    if (d == 0) return 4;
    if (d == 1) return 3;
    return 0;
  endfunction

  // Memory contents: fixed A,B,C,.. from 3000, or a salted hash of the address
  function automatic logic [15:0] memf(input logic [15:0] a, input logic fixed,
                                       input logic [15:0] s);
    logic [15:0] h;
    h = a * 16'h9E37;
    if (fixed) return 16'h000A + (a - 16'h3000);
    return h ^ s;
  endfunction

  // Combinational debug reads of the processor model
  always_comb begin
    for (int d = 0; d < N_DUT; d++) begin
      rf_data_s[d]  = rf_model[rf_addr_w[d]];
      mem_data_s[d] = memf(mem_addr_w[d], mem_fixed, salt);
    end
  end

  punc_state_dumper #(.MEM_BASE(16'h3000), .MEM_WORDS(4), .HALT_CYCLES(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .auto_en(auto_s[0]),
    .pc_debug_data(pc), .rf_debug_data(rf_data_s[0]), .mem_debug_data(mem_data_s[0]),
    .rf_debug_addr(rf_addr_w[0]), .mem_debug_addr(mem_addr_w[0]),
    .out_valid(valid_w[0]), .out_ready(ready_s[0]), .out_data(data_w[0]),
    .out_tag(tag_w[0]), .out_idx(idx_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .halted(halted_w[0]));

  punc_state_dumper #(.MEM_BASE(16'hFFFE), .MEM_WORDS(3), .HALT_CYCLES(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .auto_en(auto_s[1]),
    .pc_debug_data(pc), .rf_debug_data(rf_data_s[1]), .mem_debug_data(mem_data_s[1]),
    .rf_debug_addr(rf_addr_w[1]), .mem_debug_addr(mem_addr_w[1]),
    .out_valid(valid_w[1]), .out_ready(ready_s[1]), .out_data(data_w[1]),
    .out_tag(tag_w[1]), .out_idx(idx_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .halted(halted_w[1]));

  punc_state_dumper #(.MEM_BASE(16'h3000), .MEM_WORDS(0), .HALT_CYCLES(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .auto_en(auto_s[2]),
    .pc_debug_data(pc), .rf_debug_data(rf_data_s[2]), .mem_debug_data(mem_data_s[2]),
    .rf_debug_addr(rf_addr_w[2]), .mem_debug_addr(mem_addr_w[2]),
    .out_valid(valid_w[2]), .out_ready(ready_s[2]), .out_data(data_w[2]),
    .out_tag(tag_w[2]), .out_idx(idx_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .halted(halted_w[2]));

  // Reference stream: PC word, eight RF words, then the memory window
  task automatic build_exp(input int d, input logic [15:0] pcv);
    logic [15:0] a;
    exp_q.delete();
    exp_q.push_back({2'b00, 16'd0, pcv});
    for (int i = 0; i < 8; i++) exp_q.push_back({2'b01, 16'(i), rf_model[i]});
    for (int i = 0; i < words_of(d); i++) begin
      a = base_of(d) + 16'(i);
      exp_q.push_back({2'b10, 16'(i), memf(a, mem_fixed, salt)});
    end
  endtask

  task automatic randomize_state();
    for (int i = 0; i < 8; i++) rf_model[i] = 16'($urandom);
    salt      = 16'($urandom);
    mem_fixed = 1'b0;
  endtask

  // Pulse start around one posedge; tcyc is the cycle number of that edge
  task automatic fire(input int d, output int tcyc);
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    tcyc = cyc;
  endtask

  // Drive out_ready per mode (0 always, 1 pattern 1-0-0-1, 2 random) and
  // record accepted words. Runs until three cycles past the first done.
  task automatic collect(input int d, input int mode, input bit poke, input int budget,
                         output int viol, output int ndone, output int done_cyc,
                         output int nlow);
    logic [33:0] prev;
    logic [33:0] cur;
    bit          held;
    bit          r;
    int          after;
    got_q.delete();
    viol = 0; ndone = 0; done_cyc = -1; nlow = 0; held = 0; prev = '0; after = -1;
    for (int c = 0; c < budget; c++) begin
      cur = {tag_w[d], idx_w[d], data_w[d]};
      if (done_w[d]) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = cyc; after = 0; end
      end
      if (!halted_w[d]) nlow++;
      if (held && (!valid_w[d] || cur != prev)) viol++;
      case (mode)
        0:       r = 1'b1;
        1:       r = ((c % 4) == 0) || ((c % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ready_s[d] = r;
      if (poke) begin
        start_s[d] = (c == 5);
        if (c == 2)  pc = pc + 16'h0101;
        if (c == 7)  auto_s[d] = 1'b1;
        if (c == 20) auto_s[d] = 1'b0;
      end
      if (valid_w[d] && r) got_q.push_back(cur);
      held = valid_w[d] && !r;
      prev = cur;
      if (after >= 0) begin
        if (after == 3) break;
        after++;
      end
      @(negedge clk);
    end
    start_s[d] = 1'b0;
    ready_s[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rf_addr_w[0] !== 3'd0) begin errors++; $display("FAIL reset_rf_addr got=%h exp=0", rf_addr_w[0]); end
    checks++; if (mem_addr_w[0] !== 16'h3000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=3000", mem_addr_w[0]); end
    checks++; if (mem_addr_w[1] !== 16'hFFFE) begin errors++; $display("FAIL reset_mem_addr1 got=%h exp=fffe", mem_addr_w[1]); end
    checks++; if (valid_w[0] !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_w[0]); end
    checks++; if (data_w[0] !== 16'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_w[0]); end
    checks++; if (tag_w[0] !== 2'd0) begin errors++; $display("FAIL reset_tag got=%h exp=0", tag_w[0]); end
    checks++; if (idx_w[0] !== 16'd0) begin errors++; $display("FAIL reset_idx got=%h exp=0", idx_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_w[0]); end
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_w[0]); end
    checks++; if (halted_w[0] !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted_w[0]); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halt_dump();
    int tcyc, viol, ndone, dcyc, nlow;
    for (int i = 0; i < 8; i++) rf_model[i] = 16'(i + 1);
    mem_fixed = 1'b1;
    for (int i = 0; i < 4; i++) begin pc = 16'h1000 + 16'(i); @(negedge clk); end
    auto_s[0] = 1'b1;
    pc = 16'h3010;
    for (int i = 1; i <= 8; i++) @(negedge clk);
    checks++; if (halted_w[0] !== 1'b0) begin errors++; $display("FAIL halt_early got=%b exp=0", halted_w[0]); end
    @(negedge clk);
    checks++; if (halted_w[0] !== 1'b1) begin errors++; $display("FAIL halt_rise got=%b exp=1", halted_w[0]); end
    tcyc = cyc + 1;
    @(negedge clk);
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL halt_busy got=%b exp=1", busy_w[0]); end
    build_exp(0, 16'h3010);
    collect(0, 0, 1'b0, 100, viol, ndone, dcyc, nlow);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL halt_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL halt_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL halt_ndone got=%0d exp=1", ndone); end
    // Trigger cycle counts as the first of 1+2*13 cycles, so done is 26 edges later
    checks++; if (dcyc - tcyc !== 26) begin errors++; $display("FAIL halt_latency got=%0d exp=26", dcyc - tcyc); end
    auto_s[0] = 1'b0;
    mem_fixed = 1'b0;
  endtask

  task automatic test_backpressure();
    int tcyc, viol, ndone, dcyc, nlow;
    randomize_state();
    pc = 16'($urandom);
    @(negedge clk);
    fire(0, tcyc);
    build_exp(0, pc);
    collect(0, 1, 1'b0, 200, viol, ndone, dcyc, nlow);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", viol); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL bp_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_auto_off();
    int tcyc, viol, ndone, dcyc, nlow;
    randomize_state();
    auto_s[0] = 1'b0;
    pc = pc + 16'h0333;
    repeat (12) @(negedge clk);
    checks++; if (halted_w[0] !== 1'b1) begin errors++; $display("FAIL aoff_halted got=%b exp=1", halted_w[0]); end
    checks++; if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin errors++; $display("FAIL aoff_idle busy=%b valid=%b exp=0,0", busy_w[0], valid_w[0]); end
    fire(0, tcyc);
    build_exp(0, pc);
    collect(0, 0, 1'b0, 100, viol, ndone, dcyc, nlow);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL aoff_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL aoff_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (nlow !== 0) begin errors++; $display("FAIL aoff_halted_low got=%0d exp=0", nlow); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL aoff_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_start_while_busy();
    int tcyc, viol, ndone, dcyc, nlow;
    logic [15:0] pcv;
    randomize_state();
    pcv = pc;
    fire(0, tcyc);
    build_exp(0, pcv);
    collect(0, 0, 1'b1, 100, viol, ndone, dcyc, nlow);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL busy_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_ndone got=%0d exp=1", ndone); end
    ready_s[0] = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin errors++; $display("FAIL busy_requeue busy=%b valid=%b exp=0,0", busy_w[0], valid_w[0]); end
    ready_s[0] = 1'b0;
  endtask

  task automatic test_window(input int d, input string nm);
    int tcyc, viol, ndone, dcyc, nlow;
    randomize_state();
    pc = 16'($urandom);
    @(negedge clk);
    fire(d, tcyc);
    build_exp(d, pc);
    collect(d, 0, 1'b0, 100, viol, ndone, dcyc, nlow);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", nm, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_word[%0d] got=%h exp=%h", nm, i, got_q[i], exp_q[i]); end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL %s_ndone got=%0d exp=1", nm, ndone); end
    checks++; if (dcyc - tcyc !== 2 * (9 + words_of(d))) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", nm, dcyc - tcyc, 2 * (9 + words_of(d))); end
  endtask

  task automatic test_reset_mid();
    int tcyc, viol, ndone, dcyc, nlow;
    bit hit;
    randomize_state();
    fire(0, tcyc);
    hit = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid_w[0] && tag_w[0] == 2'b01 && idx_w[0] == 16'd3) begin hit = 1; break; end
      ready_s[0] = 1'b1;
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmid_reach got=0 exp=1"); end
    rst = 1'b1;
    #1;
    checks++; if (valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin errors++; $display("FAIL rmid_async valid=%b busy=%b done=%b exp=0,0,0", valid_w[0], busy_w[0], done_w[0]); end
    checks++; if (halted_w[0] !== 1'b0) begin errors++; $display("FAIL rmid_halted got=%b exp=0", halted_w[0]); end
    checks++; if (mem_addr_w[0] !== 16'h3000) begin errors++; $display("FAIL rmid_mem_addr got=%h exp=3000", mem_addr_w[0]); end
    ready_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    randomize_state();
    fire(0, tcyc);
    build_exp(0, pc);
    collect(0, 2, 1'b0, 200, viol, ndone, dcyc, nlow);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL rmid_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_back_to_back();
    int tcyc, viol, ndone, dcyc, nlow;
    for (int k = 0; k < 3; k++) begin
      randomize_state();
      fire(0, tcyc);
      build_exp(0, pc);
      collect(0, 2, 1'b0, 200, viol, ndone, dcyc, nlow);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b%0d_count got=%0d exp=%0d", k, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d_word[%0d] got=%h exp=%h", k, i, got_q[i], exp_q[i]); end
      end
      checks++; if (viol !== 0) begin errors++; $display("FAIL b2b%0d_stable got=%0d exp=0", k, viol); end
    end
  endtask

  initial begin
    rst = 1'b1;
    pc = 16'd0;
    mem_fixed = 1'b0;
    salt = 16'd0;
    for (int i = 0; i < 8; i++) rf_model[i] = 16'd0;
    for (int d = 0; d < N_DUT; d++) begin
      start_s[d] = 1'b0; auto_s[d] = 1'b0; ready_s[d] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_halt_dump();
    test_backpressure();
    test_auto_off();
    test_start_while_busy();
    test_window(1, "wrap");
    test_window(2, "empty");
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
